// File: rtl/hdmi_text_pkg.sv
// Shared constants, response codes, FSM state types and decode helpers for the
// text-mode VRAM / palette AXI4-Lite slave.
package hdmi_text_pkg;

    localparam int COLS_WORDS  = 40;
    localparam int ROWS        = 30;
    localparam int VRAM_WORDS  = COLS_WORDS * ROWS;
    localparam int PAL_ENTRIES = 8;
    localparam logic [11:0] PAL_BASE = 12'h800;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;

    function automatic logic is_vram(input logic [11:0] idx);
        return idx < 12'(VRAM_WORDS);
    endfunction

    // Palette occupies an 8-aligned block, so the low 3 index bits select the entry.
    function automatic logic is_pal(input logic [11:0] idx);
        return idx[11:3] == PAL_BASE[11:3];
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/text_vram.sv
// True dual-port 1200x32 VRAM: port A byte-masked read/write, port B read-only.
// Both read ports are registered; out-of-range addresses read as zero.
module text_vram
    import hdmi_text_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [10:0] i_a_addr,
    input  logic [3:0]  i_a_we,
    input  logic [31:0] i_a_wdata,
    output logic [31:0] o_a_rdata,
    input  logic [10:0] i_b_addr,
    output logic [31:0] o_b_rdata
);

    logic [31:0] r_mem [VRAM_WORDS];
    logic [31:0] r_a_rdata;
    logic [31:0] r_b_rdata;

    // Array contents are deliberately not reset so the memory maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_a_addr < 11'(VRAM_WORDS)) begin
            for (int b = 0; b < 4; b++) begin
                if (i_a_we[b]) r_mem[i_a_addr][8*b +: 8] <= i_a_wdata[8*b +: 8];
            end
        end
    end

    // Reads return the pre-write contents when the same word is written this cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_a_rdata <= (i_a_addr < 11'(VRAM_WORDS)) ? r_mem[i_a_addr] : '0;
            r_b_rdata <= (i_b_addr < 11'(VRAM_WORDS)) ? r_mem[i_b_addr] : '0;
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/hdmi_text_vram_axi_slave.sv
// AXI4-Lite host side of the text VRAM and palette; serves the display read port
// for color_mapper on VRAM port B.
module hdmi_text_vram_axi_slave
    import hdmi_text_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = 14,
    parameter int C_AXI_DATA_WIDTH = 32
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic                          axi_awvalid,
    output logic                          axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
    input  logic [3:0]                    axi_wstrb,
    input  logic                          axi_wvalid,
    output logic                          axi_wready,
    output logic [1:0]                    axi_bresp,
    output logic                          axi_bvalid,
    input  logic                          axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic                          axi_arvalid,
    output logic                          axi_arready,
    output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]                    axi_rresp,
    output logic                          axi_rvalid,
    input  logic                          axi_rready,
    input  logic [10:0]                   disp_addr,
    output logic [31:0]                   disp_data,
    output logic [PAL_ENTRIES-1:0][31:0]  palette
);

    // Every channel is a strict valid/ready pair: a beat transfers on the rising
    // edge where both are high; valid, once raised, holds its payload until then.
    wr_state_t r_wr_state, w_wr_next;
    rd_state_t r_rd_state, w_rd_next;

    logic r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0] r_bresp, r_rresp;
    logic [31:0] r_rdata, r_wdata;
    logic [3:0] r_wstrb;
    logic r_aw_held, r_w_held;
    logic [11:0] r_wr_idx, r_rd_idx;
    logic [PAL_ENTRIES-1:0][31:0] r_palette;

    logic w_aw_hs, w_w_hs, w_ar_hs, w_aw_keep, w_w_keep, w_wr_exec;
    logic w_wr_mapped, w_rd_mapped, w_rd_hit, w_unused;
    logic [10:0] w_a_addr;
    logic [3:0] w_a_we;
    logic [31:0] w_a_rdata, w_rd_base, w_rd_word;

    assign w_aw_hs   = axi_awvalid && r_awready;
    assign w_w_hs    = axi_wvalid && r_wready;
    assign w_ar_hs   = axi_arvalid && r_arready;
    assign w_wr_exec = (r_wr_state == W_EXEC);
    assign w_unused  = ^{axi_awaddr[1:0], axi_araddr[1:0]};

    always_comb begin
        w_wr_next = r_wr_state;
        unique case (r_wr_state)
            W_IDLE:  if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) w_wr_next = W_EXEC;
            W_EXEC:  w_wr_next = W_RESP;
            W_RESP:  if (axi_bready) w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
    end

    assign w_aw_keep   = (r_wr_state == W_IDLE) && (r_aw_held || w_aw_hs) && (w_wr_next == W_IDLE);
    assign w_w_keep    = (r_wr_state == W_IDLE) && (r_w_held || w_w_hs) && (w_wr_next == W_IDLE);
    assign w_wr_mapped = is_vram(r_wr_idx) || is_pal(r_wr_idx);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_wr_state <= W_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_palette  <= '0;
        end else begin
            r_wr_state <= w_wr_next;
            r_aw_held  <= w_aw_keep;
            r_w_held   <= w_w_keep;
            r_awready  <= (w_wr_next == W_IDLE) && !w_aw_keep;
            r_wready   <= (w_wr_next == W_IDLE) && !w_w_keep;
            r_bvalid   <= (w_wr_next == W_RESP);
            if (w_aw_hs) r_wr_idx <= axi_awaddr[13:2];
            if (w_w_hs) begin
                r_wdata <= axi_wdata;
                r_wstrb <= axi_wstrb;
            end
            if (w_wr_exec) begin
                r_bresp <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
                if (is_pal(r_wr_idx))
                    r_palette[r_wr_idx[2:0]] <= merge_bytes(r_palette[r_wr_idx[2:0]], r_wdata, r_wstrb);
            end
        end
    end

    always_comb begin
        w_rd_next = r_rd_state;
        unique case (r_rd_state)
            R_IDLE:  if (w_ar_hs) w_rd_next = R_WAIT;
            R_WAIT:  w_rd_next = R_DATA;
            R_DATA:  if (axi_rready) w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    // The read issues on port A in its AR cycle. A write committing during R_WAIT
    // to the same word is merged in, which gives write-first ordering.
    assign w_rd_mapped = is_vram(r_rd_idx) || is_pal(r_rd_idx);
    assign w_rd_base   = is_vram(r_rd_idx) ? w_a_rdata :
                         is_pal(r_rd_idx)  ? r_palette[r_rd_idx[2:0]] : '0;
    assign w_rd_hit    = w_wr_exec && w_rd_mapped && (r_wr_idx == r_rd_idx);
    assign w_rd_word   = w_rd_hit ? merge_bytes(w_rd_base, r_wdata, r_wstrb) : w_rd_base;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_rd_idx   <= '0;
        end else begin
            r_rd_state <= w_rd_next;
            r_arready  <= (w_rd_next == R_IDLE) && (w_wr_next != W_EXEC);
            r_rvalid   <= (w_rd_next == R_DATA);
            if (w_ar_hs) r_rd_idx <= axi_araddr[13:2];
            if (r_rd_state == R_WAIT) begin
                r_rdata <= w_rd_word;
                r_rresp <= w_rd_mapped ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign w_a_addr = w_wr_exec ? r_wr_idx[10:0] : axi_araddr[12:2];
    assign w_a_we   = (w_wr_exec && is_vram(r_wr_idx)) ? r_wstrb : 4'b0000;

    text_vram u_text_vram (
        .i_clk     (axi_aclk),
        .i_rst_n   (axi_aresetn),
        .i_a_addr  (w_a_addr),
        .i_a_we    (w_a_we),
        .i_a_wdata (r_wdata),
        .o_a_rdata (w_a_rdata),
        .i_b_addr  (disp_addr),
        .o_b_rdata (disp_data)
    );

    assign axi_awready = r_awready;
    assign axi_wready  = r_wready;
    assign axi_bvalid  = r_bvalid;
    assign axi_bresp   = r_bresp;
    assign axi_arready = r_arready;
    assign axi_rvalid  = r_rvalid;
    assign axi_rdata   = r_rdata;
    assign axi_rresp   = r_rresp;
    assign palette     = r_palette;

endmodule

// File: tb/tb_hdmi_text_vram_axi_slave.sv
// Directed bench for hdmi_text_vram_axi_slave: AXI write/read paths, palette,
// decode errors, backpressure, async reset and port-A/port-B collisions.
module tb_hdmi_text_vram_axi_slave;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn = 1'b0;
    logic [13:0] axi_awaddr = '0;
    logic        axi_awvalid = 1'b0;
    logic        axi_awready;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wstrb = '0;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready = 1'b0;
    logic [13:0] axi_araddr = '0;
    logic        axi_arvalid = 1'b0;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready = 1'b0;
    logic [10:0] disp_addr = '0;
    logic [31:0] disp_data;
    logic [7:0][31:0] palette;

    int errors = 0;
    int checks = 0;

    always #5 axi_aclk = ~axi_aclk;

    hdmi_text_vram_axi_slave dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .axi_awaddr  (axi_awaddr),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_araddr  (axi_araddr),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .palette     (palette)
    );

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic send_aw(input logic [13:0] a, output bit ok);
        axi_awaddr = a;
        axi_awvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = axi_awready;
            tick();
        end
        axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, output bit ok);
        axi_wdata = d;
        axi_wstrb = s;
        axi_wvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = axi_wready;
            tick();
        end
        axi_wvalid = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] resp, output bit ok);
        axi_bready = 1'b1;
        ok = 1'b0;
        resp = 2'bxx;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (axi_bvalid) begin
                ok = 1'b1;
                resp = axi_bresp;
            end
            tick();
        end
        axi_bready = 1'b0;
    endtask

    task automatic do_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output bit ok);
        bit ok_aw, ok_w, ok_b;
        send_aw(a, ok_aw);
        send_w(d, s, ok_w);
        get_b(resp, ok_b);
        ok = ok_aw && ok_w && ok_b;
    endtask

    task automatic do_read(input logic [13:0] a, output logic [31:0] d, output logic [1:0] r,
                           output int lat, output bit ok);
        axi_araddr = a;
        axi_arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = axi_arready;
            tick();
        end
        axi_arvalid = 1'b0;
        lat = 1;
        while (!axi_rvalid && lat < 20) begin
            tick();
            lat++;
        end
        ok = ok && axi_rvalid;
        d = axi_rdata;
        r = axi_rresp;
        axi_rready = 1'b1;
        tick();
        axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake: got %b required 00000",
                     {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid});
        end
        checks++;
        if ({axi_bresp, axi_rresp, axi_rdata, disp_data} !== 68'h0 || palette !== '0) begin
            errors++;
            $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h disp=%h palette=%h",
                     axi_bresp, axi_rresp, axi_rdata, disp_data, palette);
        end
        #10 axi_aresetn = 1'b1;
        checks++;
        if (axi_awready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b required 0", axi_awready);
        end
        tick();
        checks++;
        if ({axi_awready, axi_wready, axi_arready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_edge: got %b required 111", {axi_awready, axi_wready, axi_arready});
        end
    endtask

    task automatic test_aw_then_w();
        bit ok;
        bit ok_aw, ok_w;
        logic [1:0] resp;
        logic [31:0] rd;
        int lat;
        send_aw(14'h0000, ok_aw);
        tick();
        tick();
        send_w(32'h4F1A_2B3C, 4'hF, ok_w);
        get_b(resp, ok);
        checks++;
        if (!(ok && ok_aw && ok_w) || resp !== 2'b00) begin
            errors++;
            $display("FAIL aw_then_w_bresp: got ok=%0d resp=%b required ok=1 resp=00", ok && ok_aw && ok_w, resp);
        end
        disp_addr = 11'd0;
        tick();
        checks++;
        if (disp_data !== 32'h4F1A_2B3C) begin
            errors++;
            $display("FAIL aw_then_w_disp: got %h required 4f1a2b3c", disp_data);
        end
        do_read(14'h0000, rd, resp, lat, ok);
        checks++;
        if (!ok || rd !== 32'h4F1A_2B3C || resp !== 2'b00 || lat != 2) begin
            errors++;
            $display("FAIL aw_then_w_read: got ok=%0d data=%h resp=%b lat=%0d required 1 4f1a2b3c 00 2",
                     ok, rd, resp, lat);
        end
    endtask

    task automatic test_w_then_aw_strobe();
        bit ok, ok_aw, ok_w;
        logic [1:0] resp;
        logic [31:0] rd;
        int lat;
        do_write(14'h0004, 32'h1122_3344, 4'hF, resp, ok);
        send_w(32'h0000_AB00, 4'b0010, ok_w);
        tick();
        send_aw(14'h0004, ok_aw);
        get_b(resp, ok);
        checks++;
        if (!(ok && ok_aw && ok_w) || resp !== 2'b00) begin
            errors++;
            $display("FAIL w_then_aw_bresp: got ok=%0d resp=%b required ok=1 resp=00", ok && ok_aw && ok_w, resp);
        end
        do_read(14'h0004, rd, resp, lat, ok);
        checks++;
        if (!ok || rd !== 32'h1122_AB44 || resp !== 2'b00) begin
            errors++;
            $display("FAIL w_then_aw_read: got ok=%0d data=%h resp=%b required 1 1122ab44 00", ok, rd, resp);
        end
        disp_addr = 11'd1;
        tick();
        checks++;
        if (disp_data !== 32'h1122_AB44) begin
            errors++;
            $display("FAIL w_then_aw_disp: got %h required 1122ab44", disp_data);
        end
    endtask

    task automatic test_palette();
        bit ok, ok_aw, ok_w;
        logic [1:0] resp;
        logic [31:0] rd;
        int lat;
        send_aw(14'h2008, ok_aw);
        send_w(32'h0FFF_0F00, 4'hF, ok_w);
        checks++;
        if (palette[2] !== 32'h0) begin
            errors++;
            $display("FAIL palette_during_exec: got %h required 00000000", palette[2]);
        end
        tick();
        checks++;
        if (palette[2] !== 32'h0FFF_0F00) begin
            errors++;
            $display("FAIL palette_after_exec: got %h required 0fff0f00", palette[2]);
        end
        for (int i = 0; i < 8; i++) begin
            if (i != 2) begin
                checks++;
                if (palette[i] !== 32'h0) begin
                    errors++;
                    $display("FAIL palette_other_%0d: got %h required 00000000", i, palette[i]);
                end
            end
        end
        get_b(resp, ok);
        checks++;
        if (!(ok && ok_aw && ok_w) || resp !== 2'b00) begin
            errors++;
            $display("FAIL palette_bresp: got ok=%0d resp=%b required ok=1 resp=00", ok && ok_aw && ok_w, resp);
        end
        do_read(14'h2008, rd, resp, lat, ok);
        checks++;
        if (!ok || rd !== 32'h0FFF_0F00 || resp !== 2'b00) begin
            errors++;
            $display("FAIL palette_read: got ok=%0d data=%h resp=%b required 1 0fff0f00 00", ok, rd, resp);
        end
    endtask

    task automatic test_decode_bounds();
        bit ok;
        logic [1:0] resp;
        logic [31:0] rd;
        int lat;
        do_write(14'h12C0, 32'hDEAD_BEEF, 4'hF, resp, ok);
        checks++;
        if (!ok || resp !== 2'b10) begin
            errors++;
            $display("FAIL unmapped_write: got ok=%0d resp=%b required 1 10", ok, resp);
        end
        do_read(14'h3FFC, rd, resp, lat, ok);
        checks++;
        if (!ok || rd !== 32'h0 || resp !== 2'b10) begin
            errors++;
            $display("FAIL unmapped_read: got ok=%0d data=%h resp=%b required 1 00000000 10", ok, rd, resp);
        end
        do_write(14'h0000, 32'hFFFF_FFFF, 4'h0, resp, ok);
        checks++;
        if (!ok || resp !== 2'b00) begin
            errors++;
            $display("FAIL zero_strb_bresp: got ok=%0d resp=%b required 1 00", ok, resp);
        end
        do_read(14'h0000, rd, resp, lat, ok);
        checks++;
        if (!ok || rd !== 32'h4F1A_2B3C) begin
            errors++;
            $display("FAIL zero_strb_data: got ok=%0d data=%h required 1 4f1a2b3c", ok, rd);
        end
        do_write(14'h12BC, 32'hCAFE_0BB7, 4'hF, resp, ok);
        do_read(14'h12BC, rd, resp, lat, ok);
        checks++;
        if (!ok || rd !== 32'hCAFE_0BB7 || resp !== 2'b00) begin
            errors++;
            $display("FAIL last_word_read: got ok=%0d data=%h resp=%b required 1 cafe0bb7 00", ok, rd, resp);
        end
        disp_addr = 11'd1199;
        tick();
        checks++;
        if (disp_data !== 32'hCAFE_0BB7) begin
            errors++;
            $display("FAIL disp_last_word: got %h required cafe0bb7", disp_data);
        end
        disp_addr = 11'd1200;
        tick();
        checks++;
        if (disp_data !== 32'h0) begin
            errors++;
            $display("FAIL disp_out_of_range: got %h required 00000000", disp_data);
        end
    endtask

    task automatic test_backpressure_reset();
        bit ok_aw, ok_w, ok;
        logic [1:0] resp;
        logic [31:0] rd;
        int lat;
        int bad;
        send_aw(14'h2014, ok_aw);
        send_w(32'h0ABC_0DEF, 4'hF, ok_w);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (axi_bvalid !== 1'b1 || axi_awready !== 1'b0) bad++;
        end
        checks++;
        if (!(ok_aw && ok_w) || bad != 0 || palette[5] !== 32'h0ABC_0DEF) begin
            errors++;
            $display("FAIL backpressure: got ok=%0d bad_cycles=%0d pal5=%h required 1 0 0abc0def",
                     ok_aw && ok_w, bad, palette[5]);
        end
        #3 axi_aresetn = 1'b0;
        #1;
        checks++;
        if (axi_bvalid !== 1'b0 || palette !== '0 || axi_awready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got bvalid=%b awready=%b palette=%h required 0 0 0",
                     axi_bvalid, axi_awready, palette);
        end
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        tick();
        checks++;
        if ({axi_awready, axi_wready, axi_arready, axi_bvalid} !== 4'b1110) begin
            errors++;
            $display("FAIL release_ready: got %b required 1110",
                     {axi_awready, axi_wready, axi_arready, axi_bvalid});
        end
        do_read(14'h0000, rd, resp, lat, ok);
        checks++;
        if (!ok || rd !== 32'h4F1A_2B3C) begin
            errors++;
            $display("FAIL vram_kept_over_reset: got ok=%0d data=%h required 1 4f1a2b3c", ok, rd);
        end
    endtask

    task automatic test_collision();
        bit ok;
        logic [1:0] resp;
        do_write(14'h0010, 32'hA5A5_0001, 4'hF, resp, ok);
        disp_addr = 11'd4;
        tick();
        checks++;
        if (!ok || {axi_awready, axi_wready, axi_arready} !== 3'b111 || disp_data !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL collision_setup: got ok=%0d ready=%b disp=%h required 1 111 a5a50001",
                     ok, {axi_awready, axi_wready, axi_arready}, disp_data);
        end
        axi_awaddr = 14'h0010;
        axi_wdata = 32'h600D_F00D;
        axi_wstrb = 4'hF;
        axi_araddr = 14'h0010;
        axi_awvalid = 1'b1;
        axi_wvalid = 1'b1;
        axi_arvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid = 1'b0;
        axi_arvalid = 1'b0;
        checks++;
        if (axi_arready !== 1'b0 || axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL collision_exec: got arready=%b rvalid=%b required 0 0", axi_arready, axi_rvalid);
        end
        tick();
        checks++;
        if (disp_data !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL collision_disp_old: got %h required a5a50001", disp_data);
        end
        checks++;
        if (axi_rvalid !== 1'b1 || axi_rdata !== 32'h600D_F00D || axi_rresp !== 2'b00 || axi_bvalid !== 1'b1) begin
            errors++;
            $display("FAIL collision_read: got rvalid=%b rdata=%h rresp=%b bvalid=%b required 1 600df00d 00 1",
                     axi_rvalid, axi_rdata, axi_rresp, axi_bvalid);
        end
        axi_rready = 1'b1;
        axi_bready = 1'b1;
        tick();
        axi_rready = 1'b0;
        axi_bready = 1'b0;
        checks++;
        if (disp_data !== 32'h600D_F00D || axi_rvalid !== 1'b0 || axi_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL collision_disp_new: got disp=%h rvalid=%b bvalid=%b required 600df00d 0 0",
                     disp_data, axi_rvalid, axi_bvalid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_aw_then_w();
        test_w_then_aw_strobe();
        test_palette();
        test_decode_bounds();
        test_backpressure_reset();
        test_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdmi_text_vram_axi_slave.md
Name: hdmi_text_vram_axi_slave

Overview:
- AXI4-Lite slave that is the writer/host side of the text-mode VRAM and palette consumed by color_mapper.
- Accepts CPU writes/reads of 1200 VRAM words (40x30 words, two 8-px glyph cells per word) and 8 palette registers.
- Serves the display-side word read: the address color_mapper produces comes in, the 32-bit word returns.
- Sits inside the hdmi_text_controller IP, between the AXI interconnect and color_mapper.

Parameters:
- C_AXI_ADDR_WIDTH, 14, byte address width; word index = addr[13:2].
- C_AXI_DATA_WIDTH, 32, AXI data width (fixed 32; other values unsupported).
- VRAM_WORDS, 1200, VRAM depth in 32-bit words.
- PAL_BASE, 12'h800, word index of palette[0]; palette occupies PAL_BASE..PAL_BASE+7.

Ports:
- axi_aclk  in  1  single clock for AXI and display port.
- axi_aresetn  in  1  reset, asynchronous assert, active-low.
- axi_awaddr  in  14  write address.
- axi_awvalid / axi_awready  in / out  1  AW handshake.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  byte strobes.
- axi_wvalid / axi_wready  in / out  1  W handshake.
- axi_bresp  out  2  00 OKAY, 10 SLVERR.
- axi_bvalid / axi_bready  out / in  1  B handshake.
- axi_araddr  in  14  read address.
- axi_arvalid / axi_arready  in / out  1  AR handshake.
- axi_rdata  out  32  read data.
- axi_rresp  out  2  read response.
- axi_rvalid / axi_rready  out / in  1  R handshake.
- disp_addr  in  11  word index from color_mapper (outputCP).
- disp_data  out  32  VRAM word at disp_addr, 1-cycle latency (inputCP).
- palette  out  32 x 8  palette registers, each word {4'b0, col_odd[11:0], 4'b0, col_even[11:0]}.

Behaviour:
- Interface: axi_aclk is the only clock. axi_aresetn is an asynchronous, active-low reset.
- Reset: all valid/ready outputs 0, bresp/rresp 0, rdata 0, palette all 0, disp_data 0. VRAM contents are not reset.
- awready, wready and arready go high on the first clock edge after reset deasserts.
- Write FSM:
  - W_IDLE: AW and W are accepted independently, in either order. Each channel's ready drops once that channel is latched.
  - W_EXEC: entered when both AW and W are held; lasts exactly one cycle and performs the write.
  - W_RESP: bvalid=1 until bready; then back to W_IDLE with awready=wready=1 in the next cycle.
- Write decode (index = awaddr[13:2]):
  - 0..1199 → VRAM byte-masked write by wstrb; bresp OKAY.
  - PAL_BASE..+7 → palette byte-masked write; bresp OKAY.
  - Any other index → no state change; bresp SLVERR.
  - wstrb=0 → no change; bresp OKAY.
- Read FSM:
  - R_IDLE: arready=1. On the AR handshake go to R_WAIT.
  - R_WAIT: one cycle while the BRAM read completes.
  - R_DATA: rvalid=1, rdata/rresp stable until rready; then back to R_IDLE.
  - Read latency AR handshake → rvalid: 2 cycles.
  - Read decode mirrors write decode; unmapped index returns rdata=0 with rresp SLVERR.
- Port-A arbitration: AXI read and write share BRAM port A. arready is forced low while the write FSM is in W_EXEC. A read and a write that collide are serialized write-first, so a read of the same address returns the new data.
- Display port: BRAM port B, read-only, independent of AXI.
  - disp_data is registered: the value for disp_addr sampled at edge N appears after edge N.
  - disp_addr >= 1200 returns 0.
  - A same-cycle port-A write to the same word gives old data on disp_data; new data appears the next cycle.
- Palette is driven directly from registers; a write is visible on palette the cycle after W_EXEC.
- Reset mid-transaction: both FSMs return to idle immediately, and pending AW/W/AR are discarded with no response. The master must restart.
- No outstanding-transaction pipelining: one write and one read in flight at most.

Decomposition:
- Package hdmi_text_pkg holds:
  - constants VRAM_WORDS, PAL_BASE, PAL_ENTRIES=8, COLS_WORDS=40, ROWS=30;
  - resp codes RESP_OKAY and RESP_SLVERR;
  - enums wr_state_t {W_IDLE, W_EXEC, W_RESP} and rd_state_t {R_IDLE, R_WAIT, R_DATA}.
- Sub-module text_vram: true dual-port 1200x32 BRAM with a 4-bit byte-enable on port A (read/write) and read-only port B, both with registered outputs. The top keeps both FSMs, decode and the palette registers.

Test Plan:
1. AW then W (W 3 cycles later), addr 0x0000, data 0x4F1A_2B3C, strb F → bvalid OKAY. disp_addr=0 reads 0x4F1A_2B3C one cycle later. AXI read of 0x0000 returns the same value with rvalid 2 cycles after the AR handshake.
2. W before AW; addr 0x0004 strb 4'b0010 data 0x0000_AB00 over existing 0x1122_3344 → word becomes 0x1122_AB44; bresp OKAY.
3. Palette: write 0x0FFF_0F00 to byte addr 0x2008 (palette[2]) → palette[2]=0x0FFF_0F00 the cycle after W_EXEC; other entries unchanged; readback matches.
4. Unmapped: write addr 0x12C0 (index 1200) → SLVERR with no VRAM change; read of 0x3FFC → rdata 0, SLVERR.
5. Backpressure and reset: hold bready=0 for 5 cycles → bvalid stays 1 and awready stays 0. Then assert axi_aresetn=0 mid-W_RESP → bvalid=0 and palette=0 asynchronously; awready=1 the first cycle after release.
6. Collision: write addr 0x0010 and AR to addr 0x0010 in the same cycle → read returns the newly written data. Concurrently, disp_addr=4 shows old data, then new data the next cycle.
